mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Iterative multiply/divide unit in the execute stage, alongside the ALU. Consumes the same register-file operands as the ALU (a = rs, b = rt).
- Owns the architectural HI/LO registers. Results reach writeback through the MFHI/MFLO path.
- The control unit stalls the PC while busy=1.

Parameters:
WIDTH, 32, operand width; HI/LO are WIDTH bits each; iteration count = WIDTH

Ports:
clock  input  1  rising-edge clock
resetn  input  1  asynchronous active-low reset
a  input  WIDTH  operand A (multiplicand / dividend / MTHI-MTLO source)
b  input  WIDTH  operand B (multiplier / divisor)
mdop  input  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 none
start  input  1  sampled at a rising edge while idle; launches mdop
busy  output  1  operation in progress; new starts ignored
done  output  1  one-cycle pulse: HI/LO just updated by MULT/MULTU/DIV/DIVU
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (resetn=0, async, any time including mid-operation):
  - hi=0, lo=0, busy=0, done=0.
  - State returns to IDLE; any operation in flight is discarded.
- States: IDLE, MUL, DIV, FIX.
- IDLE, start=1 at edge T0:
  - MTHI/MTLO: hi<=a / lo<=a at T0. busy stays 0, no done.
  - MULT/MULTU/DIV/DIVU: latch operands, busy=1 after T0, iteration counter=0, enter MUL or DIV.
  - mdop 000/111: no effect.
- Operand prep at T0:
  - Signed ops (MULT, DIV): latch |a| and |b|, and record sa, sb (operand MSBs).
  - Unsigned ops: latch a and b as-is.
  - |0x80000000| = 0x80000000 is treated as unsigned magnitude.
- MUL: shift-add, one multiplier bit per edge, 2*WIDTH-bit accumulator. WIDTH edges (T1..T32), then FIX.
- DIV: restoring division, one quotient bit per edge. WIDTH edges (T1..T32), then FIX.
- FIX at T33:
  - MULT with sa^sb: 2*WIDTH-bit product negated.
  - DIV: quotient negated if sa^sb; remainder negated if sa (truncating division).
  - Then {hi,lo}<=product, or lo<=quotient and hi<=remainder.
  - busy=0 and done=1 in the cycle after T33; next state IDLE.
- Latency: start edge T0 to results visible after T33, so 33 cycles. A new start is accepted at the T34 edge.
- Divide by zero (DIV/DIVU with b=0):
  - Detected at T0; no iteration.
  - hi<=a, lo<=0xFFFFFFFF at T1; busy=1 for exactly one cycle, then done=1.
- Overflow case DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (falls out of the magnitude algorithm).
- While busy:
  - start and mdop are ignored, including MTHI/MTLO.
  - hi/lo keep their pre-operation values until FIX.
- done is high for exactly one cycle per completed arithmetic operation; it is never asserted for MTHI/MTLO.
- Operand inputs are not required to stay stable after T0.

Test Plan:
1. MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. busy high for 33 cycles; done pulses once, 33 cycles after start.
2. MULT a=0xFFFFFFFD (-3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULT a=0x80000000 b=0x80000000 -> hi=0x40000000, lo=0.
3. DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100 b=7 -> lo=14, hi=2.
4. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU a=0x1234 b=0 -> hi=0x1234, lo=0xFFFFFFFF, busy exactly 1 cycle, done pulses.
5. MTHI a=0xA5A5A5A5 in IDLE -> hi updates next edge, busy=0, done=0. Then MULTU 3*4 followed by MTLO and MULT starts at cycle 5 -> both ignored; final hi=0, lo=12.
6. resetn pulsed low at cycle 10 of a DIVU -> hi=lo=0, busy=done=0 immediately. After release, a new MULTU 6*7 -> lo=42, hi=0, after 33 cycles.

Source files
------------

// File: rtl/mul_div_unit_if.sv
// Operand/command and result bundle between the execute stage and mul_div_unit.
// Handshake: a launch is a cycle with start=1 while busy=0; mdop/a/b are sampled only on that edge, and done pulses once when HI/LO take an arithmetic result.
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       mdop;
  logic             start;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [1:0]       fsm_state;

  modport master (
    output a, b, mdop, start,
    input  busy, done, hi, lo, fsm_state
  );

  modport slave (
    input  a, b, mdop, start,
    output busy, done, hi, lo, fsm_state
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative shift-add multiplier / restoring divider owning the HI/LO registers.
// One bit per cycle on operand magnitudes; signs are applied in a final FIX cycle.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input logic           clock,
  input logic           resetn,
  mul_div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opb;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               neg_lo, neg_hi, is_div, dz, done_q;

  logic op_mult, op_multu, op_div, op_divu, op_signed, op_arith, launch, b_zero;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    op_mult   = (bus.mdop == 3'b001);
    op_multu  = (bus.mdop == 3'b010);
    op_div    = (bus.mdop == 3'b011);
    op_divu   = (bus.mdop == 3'b100);
    op_signed = op_mult | op_div;
    op_arith  = op_mult | op_multu | op_div | op_divu;
    launch    = (state == IDLE) && bus.start && op_arith;
    b_zero    = (bus.b == '0);
    // 0x80000000 negates to itself, which is the correct unsigned magnitude.
    a_mag     = (op_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    b_mag     = (op_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  end

  // Shift-add: multiplier sits in acc's low half and shifts out as the product shifts in.
  logic [WIDTH:0] mul_sum;
  // Restoring divide: acc holds {remainder, dividend/quotient}.
  logic [WIDTH:0] div_shift, div_sub;
  logic           div_ge;

  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opb : '0)};
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opb});
    div_sub   = div_shift - {1'b0, opb};
  end

  logic [2*WIDTH-1:0] fix_prod;
  logic [WIDTH-1:0]   fix_quo, fix_rem;

  always_comb begin
    fix_prod = neg_lo ? -acc : acc;
    fix_quo  = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    fix_rem  = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (launch) begin
          if ((op_div || op_divu) && b_zero) state_nxt = FIX;
          else if (op_mult || op_multu)      state_nxt = MUL;
          else                               state_nxt = DIV;
        end
      end
      MUL:     if (cnt == CW'(WIDTH-1)) state_nxt = FIX;
      DIV:     if (cnt == CW'(WIDTH-1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt    <= '0;
      acc    <= '0;
      opb    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      is_div <= 1'b0;
      dz     <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && bus.mdop == 3'b101) hi_q <= bus.a;
          if (bus.start && bus.mdop == 3'b110) lo_q <= bus.a;
          if (launch) begin
            cnt    <= '0;
            opb    <= b_mag;
            is_div <= op_div | op_divu;
            dz     <= (op_div | op_divu) & b_zero;
            neg_lo <= op_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_hi <= op_div & bus.a[WIDTH-1];
            // Divide by zero keeps the raw dividend so FIX can return it in HI.
            if ((op_div || op_divu) && b_zero) acc <= {{WIDTH{1'b0}}, bus.a};
            else                               acc <= {{WIDTH{1'b0}}, a_mag};
          end
        end
        MUL: begin
          acc <= {mul_sum, acc[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
        end
        DIV: begin
          acc <= {(div_ge ? div_sub[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                  acc[WIDTH-2:0], div_ge};
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          done_q <= 1'b1;
          if (dz) begin
            hi_q <= acc[WIDTH-1:0];
            lo_q <= '1;
          end else if (is_div) begin
            hi_q <= fix_rem;
            lo_q <= fix_quo;
          end else begin
            hi_q <= fix_prod[2*WIDTH-1:WIDTH];
            lo_q <= fix_prod[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.fsm_state = state;
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus random ops
// compared against a plain-arithmetic HI/LO model.
module tb_mul_div_unit;
  localparam int W = 32;

  logic clock  = 1'b0;
  logic resetn = 1'b0;

  mul_div_unit_if #(.WIDTH(W)) bus();
  mul_div_unit #(.WIDTH(W)) dut (.clock(clock), .resetn(resetn), .bus(bus));

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   m_hi, m_lo;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: {hi, lo} from 64-bit integer arithmetic.
  function automatic logic [63:0] model_result(input logic [2:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'b001: model_result = 64'(sa * sb);
      3'b010: model_result = ua * ub;
      3'b011: begin
        if (b == 0) model_result = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          model_result = {r[31:0], q[31:0]};
        end
      end
      3'b100: begin
        if (b == 0) model_result = {a, 32'hFFFF_FFFF};
        else        model_result = {32'(ua % ub), 32'(ua / ub)};
      end
      default: model_result = {m_hi, m_lo};
    endcase
  endfunction

  task automatic run_arith(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit inject);
    logic [63:0] e;
    int lat, exp_lat;
    bit seen;
    exp_q.push_back(model_result(op, a, b));
    exp_lat = ((op == 3'b011 || op == 3'b100) && b == 0) ? 1 : 33;
    @(negedge clock);
    bus.mdop = op; bus.a = a; bus.b = b; bus.start = 1'b1;
    lat = 0; seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clock);
      bus.start = 1'b0; bus.mdop = 3'b000; bus.a = $urandom; bus.b = $urandom;
      if (inject && i == 4) begin bus.start = 1'b1; bus.mdop = 3'b110; end
      if (inject && i == 5) begin bus.start = 1'b1; bus.mdop = 3'b001; end
      if (bus.done) seen = 1;
      else if (bus.busy) begin
        lat++;
        if (lat == 10) begin
          check_eq("hold_hi", bus.hi, m_hi);
          check_eq("hold_lo", bus.lo, m_lo);
        end
      end
    end
    check_eq("done_seen", seen, 1);
    check_eq("busy_cycles", lat, exp_lat);
    e = exp_q.pop_front();
    m_hi = e[63:32];
    m_lo = e[31:0];
    check_eq("res_hi", bus.hi, m_hi);
    check_eq("res_lo", bus.lo, m_lo);
    check_eq("idle_after", bus.busy, 0);
    @(negedge clock);
    check_eq("done_one_cycle", bus.done, 0);
  endtask

  task automatic run_move(input logic [2:0] op, input logic [W-1:0] a);
    @(negedge clock);
    bus.mdop = op; bus.a = a; bus.start = 1'b1;
    if (op == 3'b101) m_hi = a;
    if (op == 3'b110) m_lo = a;
    @(negedge clock);
    bus.start = 1'b0; bus.mdop = 3'b000;
    check_eq("mt_hi", bus.hi, m_hi);
    check_eq("mt_lo", bus.lo, m_lo);
    check_eq("mt_busy", bus.busy, 0);
    check_eq("mt_done", bus.done, 0);
  endtask

  initial begin
    logic [2:0] op;
    logic [W-1:0] ra, rb;
    bus.start = 1'b0; bus.mdop = 3'b000; bus.a = '0; bus.b = '0;
    m_hi = '0; m_lo = '0;
    repeat (3) @(negedge clock);
    check_eq("rst_hi", bus.hi, 0);
    check_eq("rst_lo", bus.lo, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_done", bus.done, 0);
    resetn = 1'b1;

    run_arith(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check_eq("multu_max", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
    run_arith(3'b001, 32'hFFFF_FFFD, 32'd5, 0);
    check_eq("mult_neg", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    run_arith(3'b001, 32'h8000_0000, 32'h8000_0000, 0);
    check_eq("mult_min", {bus.hi, bus.lo}, 64'h4000_0000_0000_0000);
    run_arith(3'b011, 32'hFFFF_FFF9, 32'd2, 0);
    check_eq("div_neg", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_arith(3'b100, 32'd100, 32'd7, 0);
    check_eq("divu", {bus.hi, bus.lo}, {32'd2, 32'd14});
    run_arith(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check_eq("div_ovf", {bus.hi, bus.lo}, {32'd0, 32'h8000_0000});
    run_arith(3'b100, 32'h1234, 32'd0, 0);
    check_eq("divu_zero", {bus.hi, bus.lo}, {32'h1234, 32'hFFFF_FFFF});

    run_move(3'b101, 32'hA5A5_A5A5);
    run_move(3'b000, 32'h1111_1111);
    run_move(3'b111, 32'h2222_2222);
    run_move(3'b110, 32'h5A5A_5A5A);
    run_arith(3'b010, 32'd3, 32'd4, 1);
    check_eq("busy_ignore", {bus.hi, bus.lo}, {32'd0, 32'd12});

    // Reset in the middle of a divide discards it and clears HI/LO at once.
    run_move(3'b101, 32'hDEAD_BEEF);
    @(negedge clock);
    bus.mdop = 3'b100; bus.a = 32'd1000; bus.b = 32'd3; bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0; bus.mdop = 3'b000;
    repeat (9) @(negedge clock);
    check_eq("pre_rst_busy", bus.busy, 1);
    #2 resetn = 1'b0;
    #1;
    check_eq("mid_rst_hi", bus.hi, 0);
    check_eq("mid_rst_lo", bus.lo, 0);
    check_eq("mid_rst_busy", bus.busy, 0);
    check_eq("mid_rst_done", bus.done, 0);
    m_hi = '0; m_lo = '0;
    @(negedge clock);
    resetn = 1'b1;
    run_arith(3'b010, 32'd6, 32'd7, 0);
    check_eq("after_rst", {bus.hi, bus.lo}, {32'd0, 32'd42});

    for (int n = 0; n < 24; n++) begin
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 4))
        0:       ra = 32'h8000_0000;
        1:       ra = 32'hFFFF_FFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      if (op >= 3'b001 && op <= 3'b100) run_arith(op, ra, rb, 0);
      else                              run_move(op, ra);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
